// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_forward_unit
//  Brief    : Operand forwarding (MEM / WB / WB-hold) with x0 suppression,
//             load-use detection, bubble FSM and saturating stall counter.
//  Revision : 1.0
// ============================================================================
module hazard_forward_unit #(
    parameter int XLEN     = 32,
    parameter int NPORTS   = 2,
    parameter int LOAD_LAT = 1,
    parameter int RW_BIT   = 7,
    parameter int LD_BIT   = 2,
    parameter bit WB_HOLD  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5*NPORTS-1:0]    rd_addr,
    input  logic [NPORTS-1:0]      rd_valid,
    input  logic [XLEN*NPORTS-1:0] rf_data,
    input  logic [31:0]            ex_ir,
    input  logic [31:0]            ex_ctrl,
    input  logic [31:0]            mem_ir,
    input  logic [31:0]            mem_ctrl,
    input  logic [XLEN-1:0]        mem_y,
    input  logic [31:0]            wb_ir,
    input  logic [31:0]            wb_ctrl,
    input  logic [XLEN-1:0]        wb_data,
    output logic [XLEN*NPORTS-1:0] fwd_data,
    output logic                   stall,
    output logic                   flush_ex,
    output logic [31:0]            stall_cnt
);

    localparam logic [0:0]  c_ST_IDLE    = 1'b0;
    localparam logic [0:0]  c_ST_STALL   = 1'b1;
    localparam int          c_CNT_INIT_I = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
    localparam logic [2:0]  c_CNT_INIT   = c_CNT_INIT_I[2:0];
    localparam logic [31:0] c_CNT_MAX    = 32'hFFFF_FFFF;

    logic [4:0]      w_ex_rd;
    logic [4:0]      w_mem_rd;
    logic [4:0]      w_wb_rd;
    logic            w_mem_fwd_ok;
    logic            w_wb_wr;
    logic            w_ex_load;
    logic [NPORTS-1:0] w_port_hit;
    logic            w_hz;

    logic            w_hold_v;
    logic [4:0]      w_hold_rd;
    logic [XLEN-1:0] w_hold_data;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;
    logic            w_stall;
    logic [31:0]     r_stall_cnt;

    // Control words are only partially decoded; fold the rest away.
    logic            w_unused;
    assign w_unused = ^{ex_ir, ex_ctrl, mem_ir, mem_ctrl, wb_ir, wb_ctrl};

    assign w_ex_rd      = ex_ir[11:7];
    assign w_mem_rd     = mem_ir[11:7];
    assign w_wb_rd      = wb_ir[11:7];
    // A load result is not available in MEM yet, so it must never bypass from there.
    assign w_mem_fwd_ok = mem_ctrl[RW_BIT] && !mem_ctrl[LD_BIT];
    assign w_wb_wr      = wb_ctrl[RW_BIT];
    assign w_ex_load    = ex_ctrl[RW_BIT] && ex_ctrl[LD_BIT];

    generate
        if (WB_HOLD) begin : g_hold
            logic            r_hold_v;
            logic [4:0]      r_hold_rd;
            logic [XLEN-1:0] r_hold_data;

            // Covers a register file that returns stale data for a same-edge write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold_v    <= 1'b0;
                    r_hold_rd   <= 5'd0;
                    r_hold_data <= '0;
                end else begin
                    r_hold_v    <= w_wb_wr && (w_wb_rd != 5'd0);
                    r_hold_rd   <= w_wb_rd;
                    r_hold_data <= wb_data;
                end
            end

            assign w_hold_v    = r_hold_v;
            assign w_hold_rd   = r_hold_rd;
            assign w_hold_data = r_hold_data;
        end else begin : g_no_hold
            assign w_hold_v    = 1'b0;
            assign w_hold_rd   = 5'd0;
            assign w_hold_data = '0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [4:0]      w_addr;
            logic [XLEN-1:0] w_rf;
            logic [XLEN-1:0] w_fwd;

            assign w_addr = rd_addr[5*gi +: 5];
            assign w_rf   = rf_data[XLEN*gi +: XLEN];

            always_comb begin
                w_fwd = w_rf;
                if (w_addr == 5'd0) begin
                    w_fwd = '0;
                end else if (w_mem_fwd_ok && (w_mem_rd == w_addr)) begin
                    w_fwd = mem_y;
                end else if (w_wb_wr && (w_wb_rd == w_addr)) begin
                    w_fwd = wb_data;
                end else if (w_hold_v && (w_hold_rd == w_addr)) begin
                    w_fwd = w_hold_data;
                end
            end

            assign fwd_data[XLEN*gi +: XLEN] = w_fwd;
            assign w_port_hit[gi]            = rd_valid[gi] && (w_addr == w_ex_rd);
        end
    endgenerate

    assign w_hz = w_ex_load && (w_ex_rd != 5'd0) && (|w_port_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // First stall cycle is spent in IDLE, so STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_stall = w_hz;
                if (w_hz && (LOAD_LAT > 1)) begin
                    w_state_nxt = c_ST_STALL;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            c_ST_STALL: begin
                w_stall = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall     = w_stall;
    assign flush_ex  = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
